// File: rtl/debounced_input_port_if.sv
// Avalon-MM slave bus bundle for the debounced input port register block.
interface debounced_input_port_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/debounced_input_port.sv
// Multi-channel pushbutton/switch input port: synchroniser, per-channel debounce,
// edge capture with polarity select, interrupt mask and an Avalon-MM register window.
module debounced_input_port #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INIT_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      export_pins,
  debounced_input_port_if.slave bus,
  output logic                  irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ADDR_STATE    = 2'd0,
    ADDR_MASK     = 2'd1,
    ADDR_CAPTURE  = 2'd2,
    ADDR_POLARITY = 2'd3
  } addr_e;

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] state_r;
  logic [CNT_W-1:0] cnt_r [WIDTH];
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] capture_r;
  logic [WIDTH-1:0] polarity_r;
  logic [31:0]      readdata_r;
  logic             irq_r;

  logic [WIDTH-1:0] state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] capture_set_s;
  logic [WIDTH-1:0] capture_clr_s;
  logic [WIDTH-1:0] capture_nxt_s;
  logic [WIDTH-1:0] mask_nxt_s;
  logic [WIDTH-1:0] polarity_nxt_s;
  logic             rd_en_s;
  logic             wr_en_s;
  logic [31:0]      rdata_s;
  logic             irq_nxt_s;

  function automatic logic [31:0] pad_word(input logic [WIDTH-1:0] v);
    logic [31:0] w;
    w          = {32{1'b0}};
    w[WIDTH-1:0] = v;
    return w;
  endfunction

  function automatic logic [31:0] read_mux(
    input logic [1:0]       addr,
    input logic [WIDTH-1:0] state,
    input logic [WIDTH-1:0] mask,
    input logic [WIDTH-1:0] capture,
    input logic [WIDTH-1:0] polarity
  );
    logic [31:0] w;
    case (addr_e'(addr))
      ADDR_STATE:    w = pad_word(state);
      ADDR_MASK:     w = pad_word(mask);
      ADDR_CAPTURE:  w = pad_word(capture);
      ADDR_POLARITY: w = pad_word(polarity);
      default:       w = {32{1'b0}};
    endcase
    return w;
  endfunction

  // Upper write-data bits carry no register state.
  generate
    if (WIDTH < 32) begin : g_wdata_upper
      logic unused_wdata_s;
      assign unused_wdata_s = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  assign rd_en_s = bus.chipselect & bus.read;
  assign wr_en_s = bus.chipselect & bus.write;

  // Debounce: count consecutive disagreeing cycles, accept the level on the last one.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = CNT_ZERO;
      if (sync2_r[i] != state_r[i]) begin
        if (cnt_r[i] == CNT_LAST) begin
          state_nxt_s[i] = sync2_r[i];
          cnt_nxt_s[i]   = CNT_ZERO;
        end else begin
          cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_nxt_s[i] = CNT_ZERO;
      end
    end
  end

  // Edge detection on the debounced state, filtered by per-bit polarity.
  always_comb begin
    rise_s        = state_nxt_s & ~state_r;
    fall_s        = ~state_nxt_s & state_r;
    capture_set_s = (rise_s & ~polarity_r) | (fall_s & polarity_r);
  end

  // Register writes; a capture set wins over a same-cycle write-1-clear.
  always_comb begin
    mask_nxt_s     = mask_r;
    polarity_nxt_s = polarity_r;
    capture_clr_s  = ZERO_W;
    if (wr_en_s) begin
      case (addr_e'(bus.address))
        ADDR_MASK:     mask_nxt_s     = bus.writedata[WIDTH-1:0];
        ADDR_CAPTURE:  capture_clr_s  = bus.writedata[WIDTH-1:0];
        ADDR_POLARITY: polarity_nxt_s = bus.writedata[WIDTH-1:0];
        default:       capture_clr_s  = ZERO_W;
      endcase
    end else begin
      capture_clr_s = ZERO_W;
    end
    capture_nxt_s = (capture_r & ~capture_clr_s) | capture_set_s;
  end

  // Read data and interrupt are computed from the current register contents.
  always_comb begin
    rdata_s   = read_mux(bus.address, state_r, mask_r, capture_r, polarity_r);
    irq_nxt_s = |(capture_r & mask_r);
  end

  // Synchroniser, debounce state and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= INIT_LEVEL;
      sync2_r <= INIT_LEVEL;
      state_r <= INIT_LEVEL;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= export_pins;
      sync2_r <= sync1_r;
      state_r <= state_nxt_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Software-visible registers, read data and interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r     <= ZERO_W;
      capture_r  <= ZERO_W;
      polarity_r <= ZERO_W;
      readdata_r <= {32{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      mask_r     <= mask_nxt_s;
      capture_r  <= capture_nxt_s;
      polarity_r <= polarity_nxt_s;
      irq_r      <= irq_nxt_s;
      if (rd_en_s) begin
        readdata_r <= rdata_s;
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

  assign bus.readdata = readdata_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_debounced_input_port.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// window-based reference model of the debounced port.
module tb_debounced_input_port;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] pins    = 4'hF;
  logic         irq;
  int           n_tests = 0;
  int           n_fail  = 0;

  debounced_input_port_if bus();

  debounced_input_port #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .INIT_LEVEL(4'hF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .export_pins (pins),
    .bus         (bus),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Reference model: h[0] is the pin sample taken at the coming edge.
  logic [W-1:0] h [0:D+1];
  logic [W-1:0] m_state, m_mask, m_cap, m_pol;
  logic [31:0]  m_rdata;
  logic         m_irq;

  task automatic model_reset();
    for (int k = 0; k <= D + 1; k++) h[k] = 4'hF;
    m_state = 4'hF; m_mask = 4'h0; m_cap = 4'h0; m_pol = 4'h0;
    m_rdata = 32'h0; m_irq = 1'b0;
  endtask

  // A level is accepted once the synchronised pin (two edges late) has
  // disagreed with the accepted level for D consecutive edges.
  task automatic model_edge();
    logic [W-1:0] nxt, setb, clr;
    logic all_diff, irq_next;
    for (int k = D + 1; k > 0; k--) h[k] = h[k-1];
    h[0] = pins;
    nxt = m_state;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++) if (h[k][i] == m_state[i]) all_diff = 1'b0;
      if (all_diff) nxt[i] = ~m_state[i];
    end
    setb = (nxt & ~m_state & ~m_pol) | (~nxt & m_state & m_pol);
    if (bus.chipselect && bus.read) begin
      case (bus.address)
        2'd0: m_rdata = {28'h0, m_state};
        2'd1: m_rdata = {28'h0, m_mask};
        2'd2: m_rdata = {28'h0, m_cap};
        default: m_rdata = {28'h0, m_pol};
      endcase
    end
    irq_next = |(m_cap & m_mask);
    clr = 4'h0;
    if (bus.chipselect && bus.write) begin
      if (bus.address == 2'd1) m_mask = bus.writedata[3:0];
      if (bus.address == 2'd2) clr = bus.writedata[3:0];
      if (bus.address == 2'd3) m_pol = bus.writedata[3:0];
    end
    m_cap   = (m_cap & ~clr) | setb;
    m_irq   = irq_next;
    m_state = nxt;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [4];
    exp_rst = '{32'hF, 32'h0, 32'h0, 32'h0};
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      n_tests++;
      if (bus.readdata !== exp_rst[a]) begin
        n_fail++; $display("FAIL reset_read%0d got %h want %h", a, bus.readdata, exp_rst[a]);
      end
    end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
  endtask

  task automatic test_latency();
    logic [31:0] exp_rd;
    logic        exp_irq;
    wr(2'd3, 32'h1);
    wr(2'd1, 32'h1);
    pins[0] = 1'b0;
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_rd  = (k <= 6) ? 32'hF : 32'hE;
      exp_irq = (k >= 7);
      n_tests++;
      if (bus.readdata !== exp_rd) begin
        n_fail++; $display("FAIL latency_state clk%0d got %h want %h", k, bus.readdata, exp_rd);
      end
      n_tests++;
      if (irq !== exp_irq) begin
        n_fail++; $display("FAIL latency_irq clk%0d got %b want %b", k, irq, exp_irq);
      end
    end
    bus.chipselect = 1'b0; bus.read = 1'b0;
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h1) begin n_fail++; $display("FAIL latency_capture got %h want 1", bus.readdata); end
  endtask

  task automatic test_glitch();
    pins[1] = 1'b0;
    repeat (3) tick();
    pins[1] = 1'b1;
    repeat (8) tick();
    rd(2'd0);
    n_tests++;
    if (bus.readdata !== 32'hE) begin n_fail++; $display("FAIL glitch_state got %h want e", bus.readdata); end
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h1) begin n_fail++; $display("FAIL glitch_capture got %h want 1", bus.readdata); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL glitch_irq got %b want 1", irq); end
  endtask

  task automatic test_clear();
    wr(2'd2, 32'h1);
    tick();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL clear_irq got %b want 0", irq); end
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL clear_capture got %h want 0", bus.readdata); end
    pins[0] = 1'b1;
    repeat (8) tick();
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL clear_wrong_dir got %h want 0", bus.readdata); end
    pins[0] = 1'b0;
    repeat (5) tick();
    wr(2'd2, 32'h1);
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h1) begin n_fail++; $display("FAIL clear_vs_set got %h want 1", bus.readdata); end
  endtask

  task automatic test_mask();
    wr(2'd2, 32'hF);
    wr(2'd1, 32'h0);
    wr(2'd3, 32'h4);
    pins[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_off_irq clk%0d got %b want 0", k, irq); end
    end
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h4) begin n_fail++; $display("FAIL mask_capture got %h want 4", bus.readdata); end
    wr(2'd1, 32'h4);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq_early got %b want 0", irq); end
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_irq_rise got %b want 1", irq); end
  endtask

  task automatic test_reset_mid();
    pins = 4'hF;
    repeat (8) tick();
    pins[3] = 1'b0;
    repeat (3) tick();
    do_reset();
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_capture got %h want 0", bus.readdata); end
    rd(2'd0);
    n_tests++;
    if (bus.readdata !== 32'hF) begin n_fail++; $display("FAIL rstmid_state got %h want f", bus.readdata); end
    rd(2'd1);
    n_tests++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_mask got %h want 0", bus.readdata); end
    rd(2'd3);
    n_tests++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_pol got %h want 0", bus.readdata); end
    wr(2'd3, 32'h8);
    rd(2'd0);
    n_tests++;
    if (bus.readdata !== 32'hF) begin n_fail++; $display("FAIL rstmid_no_early got %h want f", bus.readdata); end
    rd(2'd2);
    n_tests++;
    if (bus.readdata !== 32'h8) begin n_fail++; $display("FAIL rstmid_capture_late got %h want 8", bus.readdata); end
    rd(2'd0);
    n_tests++;
    if (bus.readdata !== 32'h7) begin n_fail++; $display("FAIL rstmid_state_late got %h want 7", bus.readdata); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq got %b want 0", irq); end
  endtask

  task automatic test_random();
    int hold;
    for (int c = 0; c < 3000; c++) begin
      hold = ((c / 500) % 2 == 1) ? 12 : 4;
      for (int i = 0; i < W; i++) if ($urandom_range(0, hold) == 0) pins[i] = ~pins[i];
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.read       = 1'($urandom_range(0, 1));
      bus.write      = ($urandom_range(0, 3) == 0);
      bus.address    = 2'($urandom_range(0, 3));
      bus.writedata  = $urandom;
      tick();
      n_tests++;
      if (bus.readdata !== m_rdata) begin
        n_fail++; $display("FAIL random_readdata cyc%0d got %h want %h", c, bus.readdata, m_rdata);
      end
      n_tests++;
      if (irq !== m_irq) begin
        n_fail++; $display("FAIL random_irq cyc%0d got %b want %b", c, irq, m_irq);
      end
    end
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic test_model_agree();
    rd(2'd0);
    n_tests++;
    if (bus.readdata !== {28'h0, m_state} || bus.readdata !== m_rdata) begin
      n_fail++; $display("FAIL final_state got %h want %h", bus.readdata, m_rdata);
    end
  endtask

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.read = 1'b0;
    bus.write = 1'b0; bus.writedata = 32'h0;
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_clear();
    test_mask();
    test_reset_mid();
    do_reset();
    test_random();
    test_model_agree();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debounced_input_port.md
DEBOUNCED_INPUT_PORT -- requirements
Module: debounced_input_port

Interface
REQ-001 Parameter WIDTH, default 4: number of input channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a level (1 ms at 50 MHz), legal range 2..2^20.
REQ-003 Parameter INIT_LEVEL, default all ones (WIDTH bits): reset value of the synchroniser and debounced state, per channel.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 export  input  WIDTH  raw asynchronous channel inputs (pushbuttons, slider switches).
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 read  input  1  read strobe, qualified by chipselect.
REQ-010 write  input  1  write strobe, qualified by chipselect.
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt, active-high, registered.

Function
REQ-014 Each channel SHALL pass export through a 2-flop synchroniser before any other logic.
REQ-015 Each channel SHALL have a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits, cleared on any cycle the synchronised value equals the debounced state.
REQ-016 While the synchronised value differs from the debounced state, the counter SHALL increment; on the cycle it equals DEBOUNCE_CYCLES-1 with the difference still present, the debounced state SHALL take the synchronised value and the counter SHALL clear.
REQ-017 Pin-to-debounced-state latency SHALL be exactly 2 + DEBOUNCE_CYCLES clocks for a clean step; a pulse shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no state change.
REQ-018 The counter SHALL never wrap; it is bounded by REQ-016.
REQ-019 Register map: 0 = debounced state (RO); 1 = interrupt mask (RW); 2 = edge capture (read, write-1-to-clear); 3 = edge polarity (RW, per bit 0 = rising, 1 = falling).
REQ-020 Edge capture bit i SHALL be set on the same clock edge that debounced state i changes in the direction selected by polarity bit i; changes in the other direction SHALL not set it.
REQ-021 Edge capture bits SHALL be sticky until cleared by a write of 1 to offset 2; writing 0 SHALL have no effect.
REQ-022 Simultaneous set (REQ-020) and write-1-clear of the same bit SHALL leave the bit set.
REQ-023 irq SHALL equal the OR of (edge capture AND mask), registered, asserting one clock after the causing capture or mask update.
REQ-024 Reads SHALL return data on readdata one clock after the read strobe; bits WIDTH..31 SHALL read 0.
REQ-025 Writes to offset 0 SHALL be ignored; writedata bits WIDTH..31 SHALL be ignored.
REQ-026 Reads SHALL have no side effects.

Reset
REQ-027 On reset_n low: synchroniser flops and debounced state = INIT_LEVEL; counters = 0; mask = 0; edge capture = 0; polarity = 0; readdata = 0; irq = 0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no edge SHALL be captured from the reset value itself after release.
REQ-029 Reset deassertion SHALL be synchronised externally; the block takes no action on deassertion beyond resuming counting.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, INIT_LEVEL=4'hF)
REQ-030 Reset, read offsets 0..3 -> 0xF, 0x0, 0x0, 0x0; irq = 0.
REQ-031 Polarity=0x1, mask=0x1, export[0] 1->0 held -> offset 0 reads 0xE exactly 6 clocks after the step; capture=0x1; irq high on the next clock.
REQ-032 export[1] low for 3 clocks then high -> debounced state stays 0xF; capture unchanged; irq unchanged.
REQ-033 Capture=0x1, write 0x1 to offset 2 -> capture 0x0, irq low one clock later; repeat with a new falling edge landing on the same clock as the clear -> capture stays 0x1.
REQ-034 Bit 2 edge captured with mask=0 -> irq stays 0; then write mask=0x4 -> irq rises one clock later.
REQ-035 Assert reset_n after 3 clocks of a 1->0 step on export[3] -> after release all registers at reset values; no capture until a full 4-cycle debounce completes.
